// File: rtl/riscv_defines_pkg.sv
// Shared constants and types for the store-tag propagation path.
package riscv_defines;

  localparam int unsigned TAG_WIDTH_DEFAULT = 1;

  typedef enum logic {
    TAG_IDLE = 1'b0,
    TAG_REQ  = 1'b1
  } tag_state_e;

endpackage

// File: rtl/riscv_tag_wfifo.sv
// Generic power-of-two depth FIFO holding pending tag writes; head is read from registered storage.
module riscv_tag_wfifo #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_store_tag_unit.sv
// EX-stage store-tag unit: merges operand tags under decoder enables, buffers the write,
// and issues it to tag memory over req/gnt while back-pressuring ID when full.
module riscv_store_tag_unit
  import riscv_defines::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic                  is_store_i,
  input  logic                  enable_a_i,
  input  logic                  enable_b_i,
  input  logic [TAG_WIDTH-1:0]  tag_rs1_i,
  input  logic [TAG_WIDTH-1:0]  tag_rs2_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  flush_i,
  output logic                  ex_ready_o,
  output logic                  tag_req_o,
  input  logic                  tag_gnt_i,
  output logic [ADDR_WIDTH-1:0] tag_addr_o,
  output logic [TAG_WIDTH-1:0]  tag_wdata_o,
  output logic                  busy_o
);

  localparam int unsigned WORD_W  = ADDR_WIDTH - 2;
  localparam int unsigned ENTRY_W = WORD_W + TAG_WIDTH;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  tag_state_e           state;
  tag_state_e           state_next;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [TAG_WIDTH-1:0] wdata;
  logic [ENTRY_W-1:0]   wentry;
  logic [ENTRY_W-1:0]   head;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr_i[1:0];

  // Both enables low still yields a zero tag, so every store clears any stale tag.
  assign wdata  = ({TAG_WIDTH{enable_a_i}} & tag_rs1_i) | ({TAG_WIDTH{enable_b_i}} & tag_rs2_i);
  assign wentry = {addr_i[ADDR_WIDTH-1:2], wdata};

  assign push = id_valid_i & is_store_i & ex_ready_o & ~flush_i;
  assign pop  = (state == TAG_REQ) & tag_gnt_i;

  riscv_tag_wfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= TAG_IDLE;
    else     state <= state_next;
  end

  // Request follows occupancy after this cycle's push/pop; no same-cycle bypass of a fresh push.
  always_comb begin
    state_next = state;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    case (state)
      TAG_IDLE: if (count_next != '0) state_next = TAG_REQ;
      TAG_REQ:  if (pop) state_next = (count_next != '0) ? TAG_REQ : TAG_IDLE;
      default:  state_next = TAG_IDLE;
    endcase
  end

  // All outputs decode registered state only; none depends on tag_gnt_i.
  assign ex_ready_o  = ~full;
  assign busy_o      = ~empty;
  assign tag_req_o   = (state == TAG_REQ);
  assign tag_addr_o  = tag_req_o ? {head[ENTRY_W-1:TAG_WIDTH], 2'b00} : '0;
  assign tag_wdata_o = tag_req_o ? head[TAG_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_riscv_store_tag_unit.sv
// Directed bench for riscv_store_tag_unit with hand-computed expectations.
module tb_riscv_store_tag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic        is_store_i;
  logic        enable_a_i;
  logic        enable_b_i;
  logic [0:0]  tag_rs1_i;
  logic [0:0]  tag_rs2_i;
  logic [31:0] addr_i;
  logic        flush_i;
  logic        ex_ready_o;
  logic        tag_req_o;
  logic        tag_gnt_i;
  logic [31:0] tag_addr_o;
  logic [0:0]  tag_wdata_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  riscv_store_tag_unit #(.ADDR_WIDTH(32), .TAG_WIDTH(1), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid_i  (id_valid_i),
    .is_store_i  (is_store_i),
    .enable_a_i  (enable_a_i),
    .enable_b_i  (enable_b_i),
    .tag_rs1_i   (tag_rs1_i),
    .tag_rs2_i   (tag_rs2_i),
    .addr_i      (addr_i),
    .flush_i     (flush_i),
    .ex_ready_o  (ex_ready_o),
    .tag_req_o   (tag_req_o),
    .tag_gnt_i   (tag_gnt_i),
    .tag_addr_o  (tag_addr_o),
    .tag_wdata_o (tag_wdata_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic ea, input logic eb, input logic t1, input logic t2,
                       input logic [31:0] a);
    id_valid_i = 1'b1; is_store_i = 1'b1;
    enable_a_i = ea;   enable_b_i = eb;
    tag_rs1_i  = t1;   tag_rs2_i  = t2;
    addr_i     = a;
  endtask

  task automatic idle_id();
    id_valid_i = 1'b0; is_store_i = 1'b0;
  endtask

  task automatic head_is(input string tag, input logic [31:0] a, input logic d);
    check({tag, "_req"},  32'(tag_req_o), 32'd1);
    check({tag, "_addr"}, tag_addr_o, a);
    check({tag, "_data"}, 32'(tag_wdata_o), 32'(d));
  endtask

  initial begin
    rst = 1'b1; tag_gnt_i = 1'b0; flush_i = 1'b0;
    idle_id(); enable_a_i = 0; enable_b_i = 0; tag_rs1_i = 0; tag_rs2_i = 0; addr_i = '0;
    step(); step();
    rst = 1'b0;
    check("rst_req",   32'(tag_req_o),   32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_ready", 32'(ex_ready_o),  32'd1);
    check("rst_addr",  tag_addr_o,       32'd0);
    check("rst_data",  32'(tag_wdata_o), 32'd0);

    // Single store, enable_a only, unaligned address.
    store(1, 0, 1, 0, 32'h1003);
    step();
    head_is("t1", 32'h1000, 1'b1);
    check("t1_busy", 32'(busy_o), 32'd1);
    idle_id(); tag_gnt_i = 1'b1;
    step();
    tag_gnt_i = 1'b0;
    check("t1_req_done",  32'(tag_req_o), 32'd0);
    check("t1_busy_done", 32'(busy_o),    32'd0);
    check("t1_addr_zero", tag_addr_o,     32'd0);

    // Both enables low clears the tag; then enable_b only.
    store(0, 0, 1, 1, 32'h2000);
    step();
    idle_id();
    head_is("t2_clear", 32'h2000, 1'b0);
    tag_gnt_i = 1'b1; step(); tag_gnt_i = 1'b0;
    check("t2_busy", 32'(busy_o), 32'd0);
    store(0, 1, 0, 1, 32'h2006);
    step();
    idle_id();
    head_is("t2_b", 32'h2004, 1'b1);
    tag_gnt_i = 1'b1; step(); tag_gnt_i = 1'b0;

    // Three back-to-back stores with no grant.
    store(1, 0, 1, 0, 32'h0100);
    step();
    check("t3_ready1", 32'(ex_ready_o), 32'd1);
    store(0, 0, 1, 1, 32'h0204);
    step();
    check("t3_ready2", 32'(ex_ready_o), 32'd0);
    head_is("t3_h0", 32'h0100, 1'b1);
    store(0, 1, 0, 1, 32'h0308);
    step();
    check("t3_ready3", 32'(ex_ready_o), 32'd0);
    head_is("t3_hold1", 32'h0100, 1'b1);
    step();
    head_is("t3_hold2", 32'h0100, 1'b1);
    tag_gnt_i = 1'b1;
    step();
    tag_gnt_i = 1'b0;
    check("t3_ready_after_gnt", 32'(ex_ready_o), 32'd1);
    head_is("t3_h1", 32'h0204, 1'b0);
    step();
    idle_id();
    check("t3_third_taken", 32'(ex_ready_o), 32'd0);
    head_is("t3_h1_hold", 32'h0204, 1'b0);
    tag_gnt_i = 1'b1;
    step();
    head_is("t3_h2", 32'h0308, 1'b1);
    check("t3_ready_last", 32'(ex_ready_o), 32'd1);
    step();
    tag_gnt_i = 1'b0;
    check("t3_req_done",  32'(tag_req_o), 32'd0);
    check("t3_busy_done", 32'(busy_o),    32'd0);

    // Continuous grant, one store per cycle.
    tag_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      store(1, 0, 1'(i), 0, 32'h0400 + 32'(4 * i));
      step();
      check($sformatf("t4_ready%0d", i), 32'(ex_ready_o), 32'd1);
      head_is($sformatf("t4_w%0d", i), 32'h0400 + 32'(4 * i), 1'(i));
    end
    idle_id();
    step();
    tag_gnt_i = 1'b0;
    check("t4_req_done",  32'(tag_req_o), 32'd0);
    check("t4_busy_done", 32'(busy_o),    32'd0);

    // Flushed store is dropped.
    store(1, 0, 1, 0, 32'h0500);
    flush_i = 1'b1;
    step();
    check("t5_flush_busy", 32'(busy_o),    32'd0);
    check("t5_flush_req",  32'(tag_req_o), 32'd0);
    flush_i = 1'b0;

    // Flush while two entries queued does not cancel them.
    store(1, 0, 1, 0, 32'h0600);
    step();
    store(0, 0, 0, 0, 32'h0700);
    step();
    check("t5_full", 32'(ex_ready_o), 32'd0);
    store(1, 1, 1, 1, 32'h0800);
    flush_i = 1'b1;
    step();
    idle_id(); flush_i = 1'b0;
    head_is("t5_q0", 32'h0600, 1'b1);
    tag_gnt_i = 1'b1;
    step();
    head_is("t5_q1", 32'h0700, 1'b0);
    step();
    tag_gnt_i = 1'b0;
    check("t5_busy_done", 32'(busy_o), 32'd0);

    // Reset mid-handshake with grant asserted.
    store(1, 0, 1, 0, 32'h0900);
    step();
    store(0, 1, 0, 1, 32'h0A00);
    step();
    idle_id();
    head_is("t6_pre", 32'h0900, 1'b1);
    rst = 1'b1; tag_gnt_i = 1'b1;
    step();
    rst = 1'b0; tag_gnt_i = 1'b0;
    check("t6_req",   32'(tag_req_o),  32'd0);
    check("t6_busy",  32'(busy_o),     32'd0);
    check("t6_ready", 32'(ex_ready_o), 32'd1);
    check("t6_addr",  tag_addr_o,      32'd0);
    step();
    check("t6_req_after", 32'(tag_req_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_store_tag_unit.md
# riscv_store_tag_unit

Store-tag propagation unit in the EX stage, directly downstream of the ID-stage enable decoder. For each store it combines the address-register tag and the source-register tag under the decoder's per-operand enables, then buffers the resulting tag write. It issues each write to the tag memory over a req/gnt handshake and stalls ID when its buffer is full.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of the store byte address
- TAG_WIDTH, 1, width of one tag
- DEPTH, 2, pending tag-write buffer entries; power of two, at least 2

Ports (reset is synchronous, active-high; one clock):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid_i  in  1  ID presents a valid instruction this cycle
- is_store_i  in  1  from enable decoder: instruction is a store
- enable_a_i  in  1  from enable decoder: propagate destination-address tag
- enable_b_i  in  1  from enable decoder: propagate source-data tag
- tag_rs1_i  in  TAG_WIDTH  tag of the address base register
- tag_rs2_i  in  TAG_WIDTH  tag of the store data register
- addr_i  in  ADDR_WIDTH  store effective byte address
- flush_i  in  1  kill the instruction currently in ID
- ex_ready_o  out  1  unit can accept a store this cycle
- tag_req_o  out  1  tag-memory write request
- tag_gnt_i  in  1  tag-memory grant
- tag_addr_o  out  ADDR_WIDTH  word-aligned tag write address (bits [1:0] = 0)
- tag_wdata_o  out  TAG_WIDTH  tag value to write
- busy_o  out  1  at least one entry is pending

## Operation
- Accept: push = id_valid_i & is_store_i & ex_ready_o & ~flush_i. Non-stores are ignored; ex_ready_o does not depend on is_store_i.
- Tag computation at push: wdata = ({TAG_WIDTH{enable_a_i}} & tag_rs1_i) | ({TAG_WIDTH{enable_b_i}} & tag_rs2_i). With both enables 0, a zero tag is still written, so a store always clears the stale tag.
- Stored address: {addr_i[ADDR_WIDTH-1:2], 2'b00}.
- Buffer: DEPTH-entry FIFO with read pointer, write pointer and count (log2(DEPTH)+1 bits); pointers wrap modulo DEPTH.
- Issue FSM:
  - IDLE: tag_req_o=0. Go to REQ when count>0 at the start of the cycle.
  - REQ: tag_req_o=1 with the head entry on tag_addr_o/tag_wdata_o.
    - On tag_gnt_i: pop; stay in REQ if count after the pop is nonzero, else return to IDLE.
    - No grant: hold the request; addr and wdata stay stable until granted.
- tag_req_o is never withdrawn without a grant. tag_gnt_i while in IDLE is ignored.
- ex_ready_o = (count != DEPTH). It is purely registered-state and has no combinational path from tag_gnt_i.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty buffer: tag_req_o is not asserted in the same cycle (no bypass).
- flush_i suppresses only the current push. Queued entries always complete.
- busy_o = (count != 0).

## Timing
- Reset: count, pointers and FSM cleared; state IDLE. tag_req_o=0, busy_o=0, ex_ready_o=1, tag_addr_o=0, tag_wdata_o=0.
- Reset mid-handshake drops all pending entries; rst overrides tag_gnt_i.
- Latency: push in cycle N gives tag_req_o=1 in cycle N+1 earliest.
- Throughput: one write per cycle with a continuous grant.
- Full: with DEPTH=2, ex_ready_o falls the cycle after the second push without a pop. It rises the cycle after the next grant.
- tag_addr_o and tag_wdata_o hold the head entry whenever tag_req_o=1, and 0 otherwise.

## Structure
- riscv_defines package: TAG_WIDTH default constant and an issue-FSM state enum (TAG_IDLE, TAG_REQ).
- Sub-module riscv_tag_wfifo: generic DEPTH x (ADDR_WIDTH-2+TAG_WIDTH) FIFO with push/pop/full/empty/count. The top level holds only tag computation, the FSM and output gating.

## Test plan
- Single store, enable_a=1, enable_b=0, tag_rs1=1, tag_rs2=0, addr=0x1003, gnt at N+1 -> tag_req_o at N+1, tag_addr_o=0x1000, tag_wdata_o=1, busy_o=0 at N+2.
- enable_a=0, enable_b=0, both tags 1 -> tag_wdata_o=0 (stale tag cleared).
- Three back-to-back stores, tag_gnt_i held 0 -> ex_ready_o=0 after the second; the third is not accepted until one cycle after the first grant. Writes complete in order with stable req/addr/data.
- Continuous gnt with one store per cycle -> ex_ready_o stays 1, one write per cycle, count never exceeds 1.
- flush_i with a valid store -> no push, busy_o stays 0. Flush while 2 entries are queued -> both still written.
- rst asserted during REQ with gnt=1 -> next cycle tag_req_o=0, busy_o=0, ex_ready_o=1, no further writes.
